// File: rtl/lsu_mem_ctrl.sv
// Load/store sequencer in front of a word-wide, 1-cycle-read data memory.
// Byte/half/word CPU requests become mem_read/mem_write cycles; sub-word stores use read-modify-write.
module lsu_mem_ctrl #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [ADDR_WIDTH+1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic                  resp_err,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    input  logic [DATA_WIDTH-1:0] mem_read_data
);

    typedef enum logic [2:0] {StIdle, StRead, StWait, StWrite, StResp} state_t;

    state_t                r_state;
    logic                  r_write;
    logic [1:0]            r_size;
    logic                  r_signed;
    logic [1:0]            r_off;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_resp_valid;
    logic                  r_resp_err;
    logic [DATA_WIDTH-1:0] r_resp_rdata;
    logic                  r_mem_read;
    logic                  r_mem_write;
    logic [ADDR_WIDTH-1:0] r_mem_address;
    logic [DATA_WIDTH-1:0] r_mem_write_data;

    logic                  w_accept;
    logic                  w_misalign;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic [DATA_WIDTH-1:0] w_load;
    logic [DATA_WIDTH-1:0] w_merge;

    assign req_ready      = (r_state == StIdle) && !rst;
    assign w_accept       = req_valid && req_ready;
    assign w_misalign     = (req_size == 2'b11) ||
                            (req_size == 2'b01 && req_addr[0]) ||
                            (req_size == 2'b10 && req_addr[1:0] != 2'b00);

    assign resp_valid     = r_resp_valid;
    assign resp_err       = r_resp_err;
    assign resp_rdata     = r_resp_rdata;
    assign mem_read       = r_mem_read;
    assign mem_write      = r_mem_write;
    assign mem_address    = r_mem_address;
    assign mem_write_data = r_mem_write_data;

    // Little-endian lane extraction and extension of the word returned by memory.
    always_comb begin
        w_byte = mem_read_data[{r_off, 3'b000} +: 8];
        w_half = r_off[1] ? mem_read_data[31:16] : mem_read_data[15:0];
        case (r_size)
            2'b00:   w_load = {{24{r_signed & w_byte[7]}}, w_byte};
            2'b01:   w_load = {{16{r_signed & w_half[15]}}, w_half};
            default: w_load = mem_read_data;
        endcase
    end

    always_comb begin
        w_merge = mem_read_data;
        if (r_size == 2'b00) begin
            w_merge[{r_off, 3'b000} +: 8] = r_wdata[7:0];
        end else begin
            w_merge[{r_off[1], 4'b0000} +: 16] = r_wdata[15:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= StIdle;
            r_write          <= 1'b0;
            r_size           <= 2'b00;
            r_signed         <= 1'b0;
            r_off            <= 2'b00;
            r_wdata          <= '0;
            r_resp_valid     <= 1'b0;
            r_resp_err       <= 1'b0;
            r_resp_rdata     <= '0;
            r_mem_read       <= 1'b0;
            r_mem_write      <= 1'b0;
            r_mem_address    <= '0;
            r_mem_write_data <= '0;
        end else begin
            r_resp_valid <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        r_write  <= req_write;
                        r_size   <= req_size;
                        r_signed <= req_signed;
                        r_off    <= req_addr[1:0];
                        r_wdata  <= req_wdata;
                        if (w_misalign) begin
                            r_state      <= StResp;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                            r_resp_rdata <= '0;
                        end else begin
                            r_mem_address <= req_addr[ADDR_WIDTH+1:2];
                            if (req_write && req_size == 2'b10) begin
                                r_mem_write      <= 1'b1;
                                r_mem_write_data <= req_wdata;
                                r_state          <= StWrite;
                            end else begin
                                r_mem_read <= 1'b1;
                                r_state    <= StRead;
                            end
                        end
                    end
                end
                StRead: r_state <= StWait;
                StWait: begin
                    if (r_write) begin
                        r_mem_write      <= 1'b1;
                        r_mem_write_data <= w_merge;
                        r_state          <= StWrite;
                    end else begin
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= 1'b0;
                        r_resp_rdata <= w_load;
                        r_state      <= StResp;
                    end
                end
                StWrite: begin
                    r_resp_valid <= 1'b1;
                    r_resp_err   <= 1'b0;
                    r_resp_rdata <= '0;
                    r_state      <= StResp;
                end
                StResp:  r_state <= StIdle;
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed self-checking bench for lsu_mem_ctrl with a behavioural 1-cycle-read word memory.
module tb_lsu_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [9:0]  req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic        mem_read;
    logic        mem_write;
    logic [7:0]  mem_address;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    logic [31:0] mem [0:255];

    int checks = 0;
    int failures = 0;
    int n_rd = 0;
    int n_wr = 0;
    int n_overlap = 0;

    int          t_wait;
    int          t_lat;
    int          t_rdc;
    int          t_wrc;
    int          t_rdy;
    logic [31:0] t_rdata;
    logic        t_err;
    logic [7:0]  t_waddr;
    logic [31:0] t_wdata;

    always #5 clk = ~clk;

    lsu_mem_ctrl #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_size       (req_size),
        .req_signed     (req_signed),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_err       (resp_err),
        .resp_rdata     (resp_rdata),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data)
    );

    // Registered-read memory: read sampled before write on the same edge.
    always @(posedge clk) begin
        if (mem_read) mem_read_data <= mem[mem_address];
        if (mem_write) mem[mem_address] = mem_write_data;
    end

    always @(negedge clk) begin
        if (mem_read) n_rd <= n_rd + 1;
        if (mem_write) n_wr <= n_wr + 1;
        if (mem_read && mem_write) n_overlap <= n_overlap + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Issue one request, wait for acceptance, then trace strobes/response cycle by cycle.
    task automatic run_req(input logic wr, input logic [1:0] sz, input logic sg,
                           input logic [9:0] addr, input logic [31:0] wd, input logic hold);
        req_valid  = 1'b1;
        req_write  = wr;
        req_size   = sz;
        req_signed = sg;
        req_addr   = addr;
        req_wdata  = wd;
        t_wait = 0;
        while (!req_ready && t_wait < 20) begin
            @(posedge clk); #1;
            t_wait++;
        end
        @(posedge clk); #1;
        if (!hold) req_valid = 1'b0;
        t_lat = -1; t_rdc = -1; t_wrc = -1; t_rdy = 0;
        t_rdata = 'x; t_err = 1'bx; t_waddr = 'x; t_wdata = 'x;
        for (int c = 1; c <= 10; c++) begin
            if (req_ready) t_rdy++;
            if (mem_read) t_rdc = c;
            if (mem_write) begin
                t_wrc   = c;
                t_waddr = mem_address;
                t_wdata = mem_write_data;
            end
            if (resp_valid) begin
                t_lat   = c;
                t_rdata = resp_rdata;
                t_err   = resp_err;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    int snap_rd;
    int snap_wr;
    int resp_seen;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem_read_data = 32'h0;
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
        req_signed = 1'b0; req_addr = '0; req_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_err", 32'(resp_err), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_mem_read", 32'(mem_read), 32'd0);
        check("rst_mem_write", 32'(mem_write), 32'd0);
        check("rst_mem_address", 32'(mem_address), 32'd0);
        check("rst_mem_wdata", mem_write_data, 32'd0);
        rst = 1'b0;
        #1;
        check("ready_after_rst", 32'(req_ready), 32'd1);

        // Word store then word load
        run_req(1'b1, 2'b10, 1'b0, 10'h010, 32'hDEADBEEF, 1'b0);
        check("sw_wr_cycle", 32'(t_wrc), 32'd1);
        check("sw_no_read", 32'(t_rdc), 32'hFFFF_FFFF);
        check("sw_addr", 32'(t_waddr), 32'h04);
        check("sw_wdata", t_wdata, 32'hDEADBEEF);
        check("sw_lat", 32'(t_lat), 32'd2);
        check("sw_err", 32'(t_err), 32'd0);
        check("sw_mem", mem[4], 32'hDEADBEEF);
        run_req(1'b0, 2'b10, 1'b0, 10'h010, 32'h0, 1'b0);
        check("lw_rd_cycle", 32'(t_rdc), 32'd1);
        check("lw_lat", 32'(t_lat), 32'd3);
        check("lw_rdata", t_rdata, 32'hDEADBEEF);
        check("lw_err", 32'(t_err), 32'd0);

        // Byte loads with sign/zero extension
        mem[4] = 32'h80FF7F01;
        run_req(1'b0, 2'b00, 1'b1, 10'h012, 32'h0, 1'b0);
        check("lb_012_s", t_rdata, 32'hFFFFFFFF);
        check("lb_lat", 32'(t_lat), 32'd3);
        run_req(1'b0, 2'b00, 1'b0, 10'h013, 32'h0, 1'b0);
        check("lbu_013", t_rdata, 32'h00000080);
        run_req(1'b0, 2'b00, 1'b1, 10'h010, 32'h0, 1'b0);
        check("lb_010_s", t_rdata, 32'h00000001);
        run_req(1'b0, 2'b00, 1'b1, 10'h011, 32'h0, 1'b0);
        check("lb_011_s", t_rdata, 32'h0000007F);

        // Sub-word read-modify-write stores
        mem[4] = 32'h11223344;
        run_req(1'b1, 2'b00, 1'b0, 10'h011, 32'h000000AA, 1'b0);
        check("sb_rd_cycle", 32'(t_rdc), 32'd1);
        check("sb_wr_cycle", 32'(t_wrc), 32'd3);
        check("sb_addr", 32'(t_waddr), 32'h04);
        check("sb_wdata", t_wdata, 32'h1122AA44);
        check("sb_lat", 32'(t_lat), 32'd4);
        check("sb_rdata", t_rdata, 32'h0);
        check("sb_mem", mem[4], 32'h1122AA44);
        run_req(1'b1, 2'b01, 1'b0, 10'h012, 32'h0000BEEF, 1'b0);
        check("sh_wdata", t_wdata, 32'hBEEFAA44);
        check("sh_lat", 32'(t_lat), 32'd4);
        check("sh_mem", mem[4], 32'hBEEFAA44);

        // Half loads
        run_req(1'b0, 2'b01, 1'b1, 10'h012, 32'h0, 1'b0);
        check("lh_012_s", t_rdata, 32'hFFFFBEEF);
        run_req(1'b0, 2'b01, 1'b0, 10'h010, 32'h0, 1'b0);
        check("lhu_010", t_rdata, 32'h0000AA44);

        // Error requests: no strobes, response in cycle 1
        snap_rd = n_rd;
        snap_wr = n_wr;
        run_req(1'b0, 2'b01, 1'b0, 10'h013, 32'h0, 1'b0);
        check("err_half_lat", 32'(t_lat), 32'd1);
        check("err_half_err", 32'(t_err), 32'd1);
        check("err_half_rdata", t_rdata, 32'h0);
        run_req(1'b1, 2'b10, 1'b0, 10'h012, 32'h12345678, 1'b0);
        check("err_word_lat", 32'(t_lat), 32'd1);
        check("err_word_err", 32'(t_err), 32'd1);
        run_req(1'b0, 2'b11, 1'b0, 10'h010, 32'h0, 1'b0);
        check("err_size_lat", 32'(t_lat), 32'd1);
        check("err_size_err", 32'(t_err), 32'd1);
        check("err_size_rdata", t_rdata, 32'h0);
        check("err_no_reads", 32'(n_rd - snap_rd), 32'd0);
        check("err_no_writes", 32'(n_wr - snap_wr), 32'd0);
        check("err_mem_intact", mem[4], 32'hBEEFAA44);

        // Back-to-back with req_valid held high
        run_req(1'b0, 2'b10, 1'b0, 10'h010, 32'h0, 1'b1);
        check("b2b1_ready_low", 32'(t_rdy), 32'd0);
        check("b2b1_rdata", t_rdata, 32'hBEEFAA44);
        check("b2b1_err", 32'(t_err), 32'd0);
        run_req(1'b0, 2'b00, 1'b0, 10'h013, 32'h0, 1'b0);
        check("b2b2_accept_gap", 32'(t_wait), 32'd1);
        check("b2b2_ready_low", 32'(t_rdy), 32'd0);
        check("b2b2_lat", 32'(t_lat), 32'd3);
        check("b2b2_rdata", t_rdata, 32'h000000BE);
        check("no_overlap", 32'(n_overlap), 32'd0);

        // Reset during WAIT of a sub-word store
        mem[4] = 32'h11223344;
        snap_wr = n_wr;
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_signed = 1'b0;
        req_addr = 10'h010; req_wdata = 32'h00000055;
        @(posedge clk); #1;
        check("rm_ready_idle", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("rm_read_c1", 32'(mem_read), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("rm_mem_write", 32'(mem_write), 32'd0);
        check("rm_mem_read", 32'(mem_read), 32'd0);
        check("rm_resp_valid", 32'(resp_valid), 32'd0);
        check("rm_ready_in_rst", 32'(req_ready), 32'd0);
        check("rm_mem_address", 32'(mem_address), 32'd0);
        check("rm_mem_wdata", mem_write_data, 32'd0);
        check("rm_resp_rdata", resp_rdata, 32'd0);
        check("rm_resp_err", 32'(resp_err), 32'd0);
        rst = 1'b0;
        resp_seen = 0;
        @(posedge clk); #1;
        check("rm_ready_after", 32'(req_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            if (resp_valid) resp_seen++;
            @(posedge clk); #1;
        end
        check("rm_no_resp", 32'(resp_seen), 32'd0);
        check("rm_no_write", 32'(n_wr - snap_wr), 32'd0);
        check("rm_mem_intact", mem[4], 32'h11223344);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
